// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite transfer types for the SRAM slave: transfer encodings, bus bundles, FSM states.
// Also provides the byte-lane strobe helper used by the slave's address decode.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } transfer_kind;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } transfer_size;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } transfer_response;

    typedef struct packed {
        logic         write;
        logic [31:0]  addr;
        transfer_size size;
        transfer_kind trans;
        logic         ready;
        logic [31:0]  wdata;
        logic [2:0]   burst;
        logic [3:0]   prot;
        logic         mastlock;
    } bus_slv_in;

    typedef struct packed {
        logic [31:0]      rdata;
        logic             ready;
        transfer_response resp;
    } bus_slv_out;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } slv_state_t;

    function automatic logic [3:0] ahb_lane_strobe(transfer_size size, logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            HSIZE_8:  strb = 4'b0001 << offset;
            HSIZE_16: strb = 4'b0011 << offset;
            default:  strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// Controller-to-slave bundle: this slave's select bit, the shared slave inputs and its response.
interface ahb_sram_slave_if;
    import ahb_sram_slave_pkg::*;

    logic       sel;
    bus_slv_in  slv_in;
    bus_slv_out slv_out;

    modport master (output sel, output slv_in, input slv_out);
    modport slave  (input sel, input slv_in, output slv_out);

endinterface

// File: rtl/ahb_sram_slave_sram_array.sv
// Word-organised single-port synchronous SRAM with per-byte write enables.
// A read (all enables low) returns the addressed word one clock later; contents are never reset.
module ahb_sram_slave_sram_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a single-port SRAM with WAIT_STATES wait cycles per OKAY phase and two-cycle ERROR.
// A write completing on the edge a read is issued is parked in a one-entry buffer and merged into reads.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    ahb_sram_slave_if.slave bus
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    slv_state_t       state_q, state_d;
    logic [3:0]       cnt_q;
    logic             dp_act_q, dp_write_q;
    logic [AW-1:0]    dp_word_q;
    logic [3:0]       dp_strb_q;
    logic             pend_vld_q;
    logic [AW-1:0]    pend_word_q;
    logic [3:0]       pend_strb_q;
    logic [31:0]      pend_data_q;
    logic [31:0]      rdata_q;

    logic             ready_out;
    transfer_response resp_out;
    logic [31:0]      rdata_out, merged;
    logic [31:0]      offset;
    logic             addr_err, accept, acc_ok, acc_err;
    logic             wr_done, rd_issue, rd_show, fwd_hit;
    logic [AW-1:0]    acc_word;
    logic [3:0]       acc_strb;

    logic             arr_en;
    logic [3:0]       arr_we;
    logic [AW-1:0]    arr_addr;
    logic [31:0]      arr_wdata, arr_rdata;

    logic             unused_fields;
    assign unused_fields = ^{bus.slv_in.burst, bus.slv_in.prot, bus.slv_in.mastlock};

    assign offset   = bus.slv_in.addr - BASE_ADDR;
    assign acc_word = offset[AW+1:2];
    assign acc_strb = ahb_lane_strobe(bus.slv_in.size, offset[1:0]);

    // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets and fail the range check.
    assign addr_err = (bus.slv_in.size > HSIZE_32)
                   || (bus.slv_in.size == HSIZE_16 && offset[0])
                   || (bus.slv_in.size == HSIZE_32 && offset[1:0] != 2'b00)
                   || ({1'b0, offset} >= LIMIT);

    assign accept  = bus.sel && bus.slv_in.ready && ready_out
                  && (bus.slv_in.trans == NONSEQ || bus.slv_in.trans == SEQ);
    assign acc_ok  = accept && !addr_err;
    assign acc_err = accept && addr_err;

    assign wr_done  = (state_q == ST_READY) && dp_act_q && dp_write_q;
    assign rd_show  = (state_q == ST_READY) && dp_act_q && !dp_write_q;
    assign rd_issue = (acc_ok && !bus.slv_in.write && WAIT_STATES == 0)
                   || (state_q == ST_WAIT && cnt_q == 4'd0 && !dp_write_q);

    // Reads own the port; a write landing on a read edge is parked and drained on the next free edge.
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 4'b0000;
        arr_addr  = pend_word_q;
        arr_wdata = pend_data_q;
        if (rd_issue) begin
            arr_en   = 1'b1;
            arr_addr = (state_q == ST_WAIT) ? dp_word_q : acc_word;
        end else if (wr_done) begin
            arr_en    = 1'b1;
            arr_we    = dp_strb_q;
            arr_addr  = dp_word_q;
            arr_wdata = bus.slv_in.wdata;
        end else if (pend_vld_q) begin
            arr_en = 1'b1;
            arr_we = pend_strb_q;
        end
    end

    ahb_sram_slave_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign fwd_hit = pend_vld_q && (pend_word_q == dp_word_q);

    always_comb begin
        merged = arr_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit && pend_strb_q[i]) begin
                merged[8*i +: 8] = pend_data_q[8*i +: 8];
            end
        end
    end

    assign rdata_out = rd_show ? merged : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY, ST_ERR2: begin
                if (acc_err) begin
                    state_d = ST_ERR1;
                end else if (acc_ok && WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_READY;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_READY;
        endcase
    end

    always_comb begin
        ready_out = 1'b1;
        resp_out  = OKAY;
        case (state_q)
            ST_WAIT: ready_out = 1'b0;
            ST_ERR1: begin
                ready_out = 1'b0;
                resp_out  = ERROR;
            end
            ST_ERR2: resp_out = ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 4'd0;
            dp_act_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_word_q   <= '0;
            dp_strb_q   <= 4'b0000;
            pend_vld_q  <= 1'b0;
            pend_word_q <= '0;
            pend_strb_q <= 4'b0000;
            pend_data_q <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            rdata_q <= rdata_out;
            if (ready_out) begin
                dp_act_q <= acc_ok;
            end
            if (acc_ok) begin
                dp_write_q <= bus.slv_in.write;
                dp_word_q  <= acc_word;
                dp_strb_q  <= acc_strb;
            end
            if (acc_ok && WAIT_STATES > 0) begin
                cnt_q <= 4'(WAIT_STATES - 1);
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rd_issue && wr_done) begin
                pend_vld_q  <= 1'b1;
                pend_word_q <= dp_word_q;
                pend_strb_q <= dp_strb_q;
                pend_data_q <= bus.slv_in.wdata;
            end else if (!rd_issue && !wr_done) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign bus.slv_out = '{rdata: rdata_out, ready: ready_out, resp: resp_out};

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave wrapping a word-organised on-chip SRAM, sitting directly downstream of the bus controller on one of its `AHB_DEVICE_COUNT` select lines. It accepts the controller's shared slave-input bundle plus its own select bit, and returns `rdata`/`ready`/`resp` into the controller's response mux. Supports byte/halfword/word accesses, configurable wait states and AHB two-cycle ERROR responses.

## Interface
- `DEPTH_WORDS`, 1024: SRAM size in 32-bit words; power of two.
- `WAIT_STATES`, 0: number of `ready=0` cycles inserted in every OKAY data phase; range 0..15.
- `BASE_ADDR`, 32'h0: byte address of word 0; offset = `addr - BASE_ADDR`.
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `sel`  input  1  this slave's bit of the controller's `sel` vector.
- `slv_in`  input  bus_slv_in  shared fields: `write`, `addr[31:0]`, `size`, `trans`, `ready` (HREADY), `wdata[31:0]`; `burst`/`prot`/`mastlock` ignored.
- `slv_out`  output  bus_slv_out  `rdata[31:0]`, `ready` (HREADYOUT), `resp`.

## Operation
- Address phase accepted on a rising edge when `sel && slv_in.ready && trans ∈ {NONSEQ, SEQ}`; latch offset, write, size.
- `sel` with IDLE/BUSY, or no `sel`: no transfer; next cycle is zero-wait OKAY.
- Error check at acceptance: size > HSIZE_32; halfword with offset[0]=1; word with offset[1:0]≠0; offset ≥ DEPTH_WORDS*4 (unsigned, so `addr < BASE_ADDR` also errors). Errored transfers never touch the array.
- States: READY (`ready=1`, `resp=OKAY`), WAIT (`ready=0`, `resp=OKAY`, counter decrementing), ERR1 (`ready=0`, `resp=ERROR`), ERR2 (`ready=1`, `resp=ERROR`).
- Transitions: on accept → ERR1 if error; else WAIT if `WAIT_STATES>0` (counter = WAIT_STATES-1), else READY. WAIT → READY when counter = 0. ERR1 → ERR2. READY/ERR2 → next accept or READY.
- Byte strobes: byte → 1<<offset[1:0]; halfword → 2'b11<<offset[1:0]; word → 4'b1111.
- Write: `wdata` sampled in the final data-phase cycle (`ready=1`); strobed lanes committed to the array at that edge. Unstrobed lanes unchanged.
- Read: full 32-bit word returned on `rdata` whenever `ready=1` in an OKAY read data phase; master extracts lanes. `rdata` holds its last value otherwise.
- Write-then-read of same word back to back: read data phase returns merged (forwarded) bytes of the just-committed write.
- Array contents not reset.

## Timing
- Reset: state READY, `ready=1`, `resp=OKAY`, `rdata=0`, pending write dropped.
- Reset asserted mid-transfer: transfer abandoned, no write committed, outputs at reset values next cycle.
- OKAY data phase length = WAIT_STATES+1 cycles; ERROR data phase = exactly 2 cycles.
- Read data from a synchronous array read issued at the accepting edge (or at the last WAIT edge); no combinational path from `addr` to `rdata`.
- New address phase accepted in the same cycle the previous data phase completes (pipelined, zero-bubble at WAIT_STATES=0).

## Structure
- Shared package: existing `transfer_kind`, `transfer_size`, `transfer_response`; widen `transfer_size` to 3 bits; add function `ahb_lane_strobe(size, offset[1:0]) -> [3:0]`.
- Sub-module `sram_array`: DEPTH_WORDS×32, one synchronous read/write port, 4-bit byte write enable.
- FSM, counter, error check, forwarding in top.

## Test plan
- Word write 0xDEADBEEF to offset 0x10, read back, WAIT_STATES=0 -> read data phase `ready=1`, `rdata=0xDEADBEEF`, OKAY, 1 cycle each.
- Byte write 0xAA to offset 0x11 over 0x11223344 -> read returns 0x1122AA44.
- Halfword write at offset 0x3 -> ERR1 (`ready=0`,ERROR) then ERR2 (`ready=1`,ERROR); array word 0 unchanged.
- WAIT_STATES=3 word read -> 3 cycles `ready=0` then `ready=1` with correct data; offset DEPTH_WORDS*4 -> ERROR pair.
- Back-to-back write 0x12345678 to 0x20 then read 0x20, zero gap -> read returns 0x12345678 (forwarding).
- `rst` low during WAIT of a write -> `ready=1`, `resp=OKAY`, `rdata=0`; subsequent read shows old contents.
